ps2_rx_deser: RTL and testbench

- PS/2 device-to-host receiver; deserialises raw PS2_CLK/PS2_DATA line activity into bytes.
- Sits directly upstream of the keyboard decoder, which consumes DATA/VALID to track scan codes and E0/F0 prefixes.
- Provides metastability synchronisation, clock-line glitch filtering, frame checking (start, 8 data LSB-first, odd parity, stop) and a stuck-frame watchdog.
- Receive-only; never drives the PS/2 lines.

---
 rtl/ps2_rx_deser.sv | 131 +++++++++++++
 tb/tb_ps2_rx_deser.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_deser.sv
// PS/2 device-to-host receiver: synchronises and glitch-filters the raw lines,
// then checks each 11-bit frame and reports one byte per good frame.
module ps2_rx_deser #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       ERROR
);

  localparam int unsigned FW = 8;
  localparam int unsigned TW = 16;
  localparam int unsigned BW = 3;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] WD_LIMIT  = TW'(TIMEOUT - 2);
  localparam logic [BW-1:0] BIT_LAST  = BW'(7);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state_q;
  logic          clk_s1_q, clk_s2_q;
  logic          dat_s1_q, dat_s2_q;
  logic          filt_q;
  logic [FW-1:0] fcnt_q;
  logic [BW-1:0] bitcnt_q;
  logic [7:0]    shift_q;
  logic          par_ok_q;
  logic [TW-1:0] wd_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          error_q;

  // The filtered clock flips on the FILTER_LEN-th consecutive differing sample.
  logic filt_flip_c;
  logic fe_c;
  assign filt_flip_c = (clk_s2_q != filt_q) && (fcnt_q == FILT_LAST);
  assign fe_c        = filt_flip_c && filt_q;

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state_q  <= S_IDLE;
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_ok_q <= 1'b0;
      wd_q     <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      clk_s1_q <= PS2_CLK;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= PS2_DATA;
      dat_s2_q <= dat_s1_q;

      if (clk_s2_q == filt_q) begin
        fcnt_q <= '0;
      end else if (filt_flip_c) begin
        filt_q <= clk_s2_q;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + FW'(1);
      end

      valid_q <= 1'b0;
      error_q <= 1'b0;

      if (fe_c) begin
        wd_q <= '0;
        case (state_q)
          S_IDLE: begin
            if (!dat_s2_q) begin
              state_q  <= S_DATA;
              bitcnt_q <= '0;
            end
          end
          S_DATA: begin
            shift_q[bitcnt_q] <= dat_s2_q;
            bitcnt_q          <= bitcnt_q + BW'(1);
            if (bitcnt_q == BIT_LAST) begin
              state_q <= S_PARITY;
            end
          end
          S_PARITY: begin
            par_ok_q <= ^{shift_q, dat_s2_q};
            state_q  <= S_STOP;
          end
          S_STOP: begin
            state_q <= S_IDLE;
            if (dat_s2_q && par_ok_q) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              error_q <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (state_q == S_IDLE) begin
        wd_q <= '0;
      end else if (wd_q == WD_LIMIT) begin
        // Stuck frame: abort so ERROR appears TIMEOUT cycles after the last edge.
        state_q <= S_IDLE;
        error_q <= 1'b1;
        wd_q    <= '0;
      end else if (wd_q != '1) begin
        wd_q <= wd_q + TW'(1);
      end
    end
  end

  assign DATA  = data_q;
  assign VALID = valid_q;
  assign ERROR = error_q;

endmodule

// File: tb/tb_ps2_rx_deser.sv
// Self-checking bench for ps2_rx_deser: frame table, corner-case sequences and
// randomized frames against a byte-level model with an event scoreboard.
module tb_ps2_rx_deser;

  localparam int unsigned FL  = 4;
  localparam int unsigned TO  = 400;
  localparam int unsigned HP  = 20;
  // Pin edge to visible pulse: 2 sync flops + FL filter samples, then one register.
  localparam int unsigned LAT = FL + 2;

  logic       CLK = 1'b0;
  logic       nRESET = 1'b0;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DATA = 1'b1;
  logic [7:0] DATA;
  logic       VALID;
  logic       ERROR;

  ps2_rx_deser #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .CLK(CLK), .nRESET(nRESET), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .DATA(DATA), .VALID(VALID), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         kind;  // 1 = VALID, 2 = ERROR
    int         at;
    logic [7:0] d;
  } ev_t;
  ev_t evq[$];
  int  excl = 0;

  always @(negedge CLK) begin
    if (VALID || ERROR) evq.push_back('{(VALID ? 1 : 2), cyc, DATA});
    if (VALID && ERROR) excl = excl + 1;
  end

  int checks = 0;
  int errors = 0;
  int last_fe = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input logic flip, input logic stop);
    logic par;
    par = (~^b) ^ flip;
    return {stop, par, b, 1'b0};
  endfunction

  // Drive bits lo..hi of a frame; called and returns on a falling CLK edge.
  task automatic send(input logic [10:0] fr, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      PS2_DATA = fr[i];
      repeat (HP/2) @(negedge CLK);
      PS2_CLK = 1'b0;
      last_fe = cyc;
      repeat (HP) @(negedge CLK);
      PS2_CLK = 1'b1;
      repeat (HP/2) @(negedge CLK);
    end
  endtask

  task automatic check_ev(input string nm, input int exp_kind, input int exp_at,
                          input logic [7:0] exp_d);
    chk({nm, ".events"}, evq.size(), (exp_kind != 0) ? 1 : 0);
    if (exp_kind != 0 && evq.size() > 0) begin
      chk({nm, ".kind"}, evq[0].kind, exp_kind);
      chk({nm, ".cycle"}, evq[0].at, exp_at);
    end
    chk({nm, ".data"}, int'(DATA), int'(exp_d));
    evq.delete();
  endtask

  typedef struct {
    logic [7:0] b;
    logic       flip;
    logic       stop;
    int         kind;
    logic [7:0] exp_d;
  } vec_t;
  vec_t tbl[6];

  initial begin
    logic [7:0] last_good;
    logic [7:0] rb;
    logic       rflip, rstop;
    int         gap;

    tbl[0] = '{8'h1C, 1'b0, 1'b1, 1, 8'h1C};
    tbl[1] = '{8'h1C, 1'b1, 1'b1, 2, 8'h1C};
    tbl[2] = '{8'hF0, 1'b0, 1'b0, 2, 8'h1C};
    tbl[3] = '{8'hE0, 1'b0, 1'b1, 1, 8'hE0};
    tbl[4] = '{8'h29, 1'b0, 1'b1, 1, 8'h29};
    tbl[5] = '{8'h75, 1'b0, 1'b1, 1, 8'h75};

    repeat (3) @(negedge CLK);
    chk("reset.data", int'(DATA), 0);
    chk("reset.valid", int'(VALID), 0);
    chk("reset.error", int'(ERROR), 0);
    nRESET = 1'b1;
    repeat (10) @(negedge CLK);
    evq.delete();

    for (int i = 0; i < 6; i++) begin
      send(mk(tbl[i].b, tbl[i].flip, tbl[i].stop), 0, 10);
      check_ev($sformatf("tbl%0d", i), tbl[i].kind, last_fe + LAT, tbl[i].exp_d);
    end

    // Short low glitch in the middle of a frame must not consume a bit.
    send(mk(8'h29, 1'b0, 1'b1), 0, 3);
    PS2_CLK = 1'b0;
    repeat (FL-1) @(negedge CLK);
    PS2_CLK = 1'b1;
    repeat (HP) @(negedge CLK);
    send(mk(8'h29, 1'b0, 1'b1), 4, 10);
    check_ev("glitch", 1, last_fe + LAT, 8'h29);

    // Start + 4 data bits, then silence: watchdog aborts the frame.
    send(mk(8'h33, 1'b0, 1'b1), 0, 4);
    repeat (TO + 50) @(negedge CLK);
    check_ev("timeout", 2, last_fe + LAT - 1 + TO, 8'h29);
    send(mk(8'h75, 1'b0, 1'b1), 0, 10);
    check_ev("after_to", 1, last_fe + LAT, 8'h75);

    // Reset in the middle of a frame discards it silently.
    send(mk(8'h5A, 1'b0, 1'b1), 0, 4);
    nRESET = 1'b0;
    @(negedge CLK);
    nRESET = 1'b1;
    repeat (TO + 50) @(negedge CLK);
    check_ev("midreset", 0, 0, 8'h00);
    send(mk(8'h1C, 1'b1, 1'b1), 0, 10);
    check_ev("badpar_rst", 2, last_fe + LAT, 8'h00);
    send(mk(8'h6B, 1'b0, 1'b1), 0, 10);
    check_ev("after_rst", 1, last_fe + LAT, 8'h6B);

    // Randomized frames, including back-to-back and data-line noise while idle.
    last_good = 8'h6B;
    for (int k = 0; k < 40; k++) begin
      rb    = 8'($urandom);
      rflip = ($urandom_range(0, 3) == 0);
      rstop = ($urandom_range(0, 7) != 0);
      gap   = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 60));
      for (int g = 0; g < gap; g++) begin
        PS2_DATA = 1'($urandom);
        @(negedge CLK);
      end
      PS2_DATA = 1'b1;
      send(mk(rb, rflip, rstop), 0, 10);
      if (rstop && !rflip) last_good = rb;
      check_ev($sformatf("rnd%0d", k), (rstop && !rflip) ? 1 : 2, last_fe + LAT, last_good);
    end

    repeat (20) @(negedge CLK);
    chk("exclusive", excl, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
